// File: rtl/alu_issue_sequencer_if.sv
// Request, ALU and response signal bundle for alu_issue_sequencer.
// master = requesters/ALU/consumer side, slave = sequencer side.
`timescale 1ns/1ps
interface alu_issue_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [2:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [DATA_WIDTH-1:0] alu_data1;
  logic [DATA_WIDTH-1:0] alu_data2;
  logic [2:0]            alu_select;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_zero;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
    output alu_result, alu_zero, resp_ready,
    input  req_ready, alu_data1, alu_data2, alu_select,
    input  resp_valid, resp_id, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b,
    input  alu_result, alu_zero, resp_ready,
    output req_ready, alu_data1, alu_data2, alu_select,
    output resp_valid, resp_id, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Round-robin issue of two requesters onto one ALU, with per-opcode settle wait.
// Optional busy-cycle counter enabled by defining ALU_SEQ_PERF_EN.
`timescale 1ns/1ps
module alu_issue_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FAST_WAIT  = 1,
  parameter int unsigned ADD_WAIT   = 1,
  parameter int unsigned MUL_WAIT   = 3,
  parameter int unsigned SHIFT_WAIT = 2
) (
  input logic clk,
  input logic reset,
  alu_issue_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0] perf_busy
`endif
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  prio;
  logic                  id_q;
  logic                  grant_c;
  logic                  accept_c;
  logic                  capture_c;
  logic                  release_c;
  logic [1:0]            ready_c;
  logic [OP_W-1:0]       grant_op_c;
  logic [DATA_WIDTH-1:0] grant_a_c;
  logic [DATA_WIDTH-1:0] grant_b_c;

  // Settle cycles required by each ALU select code.
  function automatic logic [CNT_W-1:0] wait_for(input logic [OP_W-1:0] op);
    case (op)
      3'b001:                 wait_for = CNT_W'(ADD_WAIT);
      3'b100:                 wait_for = CNT_W'(MUL_WAIT);
      3'b101, 3'b110, 3'b111: wait_for = CNT_W'(SHIFT_WAIT);
      default:                wait_for = CNT_W'(FAST_WAIT);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Grant selection, handshake decode and next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_c    = 2'b00;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    release_c  = 1'b0;
    grant_c    = (&bus.req_valid) ? prio : bus.req_valid[1];
    grant_op_c = grant_c ? bus.req1_op : bus.req0_op;
    grant_a_c  = grant_c ? bus.req1_a  : bus.req0_a;
    grant_b_c  = grant_c ? bus.req1_b  : bus.req0_b;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          ready_c    = grant_c ? 2'b10 : 2'b01;
          accept_c   = 1'b1;
          cnt_next   = wait_for(grant_op_c);
          state_next = EXEC;
        end
      end
      EXEC: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          capture_c  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          release_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready = ready_c;

  // ALU operand registers and response capture; ALU drive holds after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      prio            <= 1'b0;
      id_q            <= 1'b0;
      bus.alu_data1   <= '0;
      bus.alu_data2   <= '0;
      bus.alu_select  <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_zero   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (accept_c) begin
        bus.alu_select <= grant_op_c;
        bus.alu_data1  <= grant_a_c;
        bus.alu_data2  <= grant_b_c;
        id_q           <= grant_c;
        prio           <= ~grant_c;
      end
      if (capture_c) begin
        bus.resp_valid  <= 1'b1;
        bus.resp_id     <= id_q;
        bus.resp_result <= bus.alu_result;
        bus.resp_zero   <= bus.alu_zero;
      end else if (release_c) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Saturating count of non-idle cycles.
  always_ff @(posedge clk) begin
    if (reset)                                     perf_busy <= '0;
    else if (state != IDLE && perf_busy != 16'hFFFF) perf_busy <= perf_busy + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_issue_sequencer;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_busy;
`endif

  alu_issue_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_busy (perf_busy)
`endif
  );

  // Reference ALU: FORWARD, ADD, AND, OR, MULT, SL, SRA, ROR.
  always_comb begin
    case (bus.alu_select)
      3'b000:  bus.alu_result = bus.alu_data1;
      3'b001:  bus.alu_result = bus.alu_data1 + bus.alu_data2;
      3'b010:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
      3'b011:  bus.alu_result = bus.alu_data1 | bus.alu_data2;
      3'b100:  bus.alu_result = DW'(bus.alu_data1 * bus.alu_data2);
      3'b101:  bus.alu_result = bus.alu_data1 << 1;
      3'b110:  bus.alu_result = {bus.alu_data1[DW-1], bus.alu_data1[DW-1:1]};
      default: bus.alu_result = {bus.alu_data1[0], bus.alu_data1[DW-1:1]};
    endcase
  end
  assign bus.alu_zero = (bus.alu_result == '0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Present one request, accept it and wait for the response (left un-consumed).
  task automatic issue(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int exp_wait, input logic [7:0] exp_res, input bit exp_zero,
                       input bit hold_valid, input string tag);
    int n;
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    bus.req_valid[id] = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(bus.req_ready), id ? 32'd2 : 32'd1);
    tick();
    if (!hold_valid) bus.req_valid = 2'b00;
    #1;
    check({tag, ".sel"}, 32'(bus.alu_select), 32'(op));
    check({tag, ".d1"}, 32'(bus.alu_data1), 32'(a));
    check({tag, ".d2"}, 32'(bus.alu_data2), 32'(b));
    check({tag, ".busy_ready"}, 32'(bus.req_ready), 32'd0);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (bus.resp_valid) break;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_wait));
    check({tag, ".result"}, 32'(bus.resp_result), 32'(exp_res));
    check({tag, ".zero"}, 32'(bus.resp_zero), 32'(exp_zero));
    check({tag, ".id"}, 32'(bus.resp_id), 32'(id));
  endtask

  task automatic release_resp(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    check({tag, ".released"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.resp_ready = 1'b1;
    reset = 1'b0;
    do_reset();

    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.resp_id", 32'(bus.resp_id), 32'd0);
    check("rst.result", 32'(bus.resp_result), 32'd0);
    check("rst.d1", 32'(bus.alu_data1), 32'd0);
    check("rst.sel", 32'(bus.alu_select), 32'd0);

    issue(1'b0, 3'b001, 8'd5, 8'd3, 1, 8'd8, 1'b0, 1'b0, "add0");
    release_resp("add0");

    issue(1'b1, 3'b100, 8'd6, 8'd7, 3, 8'd42, 1'b0, 1'b0, "mul1");
    release_resp("mul1");

    // Both requesters held valid: strict alternation starting at requester 0.
    do_reset();
    bus.req0_op = 3'b000; bus.req0_a = 8'h11;
    bus.req1_op = 3'b000; bus.req1_a = 8'h22;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) issue(1'b0, 3'b000, 8'h11, 8'h00, 1, 8'h11, 1'b0, 1'b1, "rr0");
      else            issue(1'b1, 3'b000, 8'h22, 8'h00, 1, 8'h22, 1'b0, 1'b1, "rr1");
      release_resp("rr");
    end
    bus.req_valid = 2'b00;

    // Back-pressured response holds stable.
    bus.resp_ready = 1'b0;
    issue(1'b0, 3'b010, 8'hF0, 8'h0F, 1, 8'h00, 1'b1, 1'b0, "and0");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.valid", 32'(bus.resp_valid), 32'd1);
      check("hold.result", 32'(bus.resp_result), 32'd0);
      check("hold.zero", 32'(bus.resp_zero), 32'd1);
    end
    release_resp("and0");
    bus.req_valid = 2'b01;
    #1;
    check("idle.ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;

    // Reset during MULT execution aborts the op.
    tick();
    bus.req0_op = 3'b100; bus.req0_a = 8'd9; bus.req0_b = 8'd9;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    check("abort.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort.result", 32'(bus.resp_result), 32'd0);
    check("abort.zero", 32'(bus.resp_zero), 32'd0);
    check("abort.id", 32'(bus.resp_id), 32'd0);
    check("abort.d1", 32'(bus.alu_data1), 32'd0);
    check("abort.d2", 32'(bus.alu_data2), 32'd0);
    check("abort.sel", 32'(bus.alu_select), 32'd0);
    check("abort.ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort.no_resp", 32'(bus.resp_valid), 32'd0);
    end
    bus.req_valid = 2'b11;
    #1;
    check("abort.grant0", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;

`ifdef ALU_SEQ_PERF_EN
    tick();
    do_reset();
    check("perf.reset", 32'(perf_busy), 32'd0);
    issue(1'b0, 3'b001, 8'd5, 8'd3, 1, 8'd8, 1'b0, 1'b0, "perf_add");
    release_resp("perf_add");
    issue(1'b0, 3'b101, 8'h81, 8'h00, 2, 8'h02, 1'b0, 1'b0, "perf_sl");
    release_resp("perf_sl");
    check("perf.busy", 32'(perf_busy), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
